// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - Packs bitstream words into fabric frames, strobes them in, then arms the fabric.
module fpga_config_loader #(
    parameter int FRAME_W    = 224,
    parameter int NUM_FRAMES = 43,
    parameter int WORD_W     = 32,
    parameter int SETTLE_CYC = 10,
    localparam int IDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_W-1:0]     cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [FRAME_W-1:0]    configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy,
    output logic [IDX_W-1:0]      frame_idx
);

    localparam int WPF  = (FRAME_W + WORD_W - 1) / WORD_W;
    localparam int WC_W = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [WC_W-1:0]  LAST_WORD   = WC_W'(WPF - 1);
    localparam logic [IDX_W-1:0] LAST_FRAME  = IDX_W'(NUM_FRAMES - 1);
    localparam logic [SC_W-1:0]  LAST_SETTLE = SC_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_SETTLE,
        S_ARM,
        S_DONE
    } state_t;

    state_t          state;
    logic [WC_W-1:0] word_cnt;
    logic [SC_W-1:0] settle_cnt;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            settle_cnt <= '0;
            frame_idx  <= '0;
            cfg_ready  <= 1'b0;
            configs_in <= '0;
            configs_en <= '0;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
            busy       <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            // configs_in is deliberately left alone; the fabric ignores it without a strobe
            state      <= S_IDLE;
            word_cnt   <= '0;
            settle_cnt <= '0;
            frame_idx  <= '0;
            cfg_ready  <= 1'b0;
            configs_en <= '0;
            ff_en      <= 1'b0;
            rdy        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        word_cnt  <= '0;
                        frame_idx <= '0;
                        cfg_ready <= 1'b1;
                        ff_en     <= 1'b0;
                        rdy       <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (cfg_valid && cfg_ready) begin
                        // Bits of the last word beyond FRAME_W fall outside the loop and are dropped
                        for (int i = 0; i < FRAME_W; i++) begin
                            if (word_cnt == WC_W'(i / WORD_W)) begin
                                configs_in[i] <= cfg_data[i % WORD_W];
                            end
                        end
                        if (word_cnt == LAST_WORD) begin
                            state     <= S_SETUP;
                            cfg_ready <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + WC_W'(1);
                        end
                    end
                end
                S_SETUP: begin
                    state      <= S_STROBE;
                    configs_en <= NUM_FRAMES'(1) << frame_idx;
                end
                S_STROBE: begin
                    state      <= S_HOLD;
                    configs_en <= '0;
                end
                S_HOLD: begin
                    if (frame_idx == LAST_FRAME) begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                    end else begin
                        state     <= S_LOAD;
                        frame_idx <= frame_idx + IDX_W'(1);
                        word_cnt  <= '0;
                        cfg_ready <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        state <= S_ARM;
                        ff_en <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SC_W'(1);
                    end
                end
                S_ARM: begin
                    state <= S_DONE;
                    rdy   <= 1'b1;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
